rx_cmd_decoder: RTL and testbench

//  Consumes the 12-bit words delivered by the ESP32 receive stage (word + 1-cycle valid).

---
 rtl/rx_cmd_decoder.sv | 127 ++++++++++++
 tb/tb_rx_cmd_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rx_cmd_decoder.sv
// Decodes 12-bit command words from the receive stage into a frequency word
// (4-byte transfer with valid/ready), mode, run enable and sticky error flags.
module rx_cmd_decoder #(
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [31:0] FREQ_INIT   = 32'd96878045,
  parameter int          MODE_W      = 2
) (
  input  logic              ExtClk,
  input  logic              ExtReset,
  input  logic [11:0]       DataIn,
  input  logic              DataInValid,
  output logic [31:0]       FreqWord,
  output logic              FreqValid,
  input  logic              FreqReady,
  output logic [MODE_W-1:0] Mode,
  output logic              Enable,
  output logic              Busy,
  output logic [3:0]        ErrFlags
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_nxt;

  logic [1:0]        idx, idx_nxt;
  logic [2:0][7:0]   bytes, bytes_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [31:0]       freq_nxt;
  logic              fvalid_nxt, enable_nxt;
  logic [MODE_W-1:0] mode_nxt;
  logic [3:0]        err_nxt, err_set;

  logic [3:0] op;
  logic [7:0] pl;
  logic is_mode, is_run, is_fstart, is_fdata, is_clear, is_bad;
  logic in_col, timeout, complete;

  assign op        = DataIn[11:8];
  assign pl        = DataIn[7:0];
  assign is_mode   = DataInValid && (op == 4'h1);
  assign is_run    = DataInValid && (op == 4'h2);
  assign is_fstart = DataInValid && (op == 4'h3);
  assign is_fdata  = DataInValid && (op == 4'h4);
  assign is_clear  = DataInValid && (op == 4'hF);
  assign is_bad    = DataInValid && !(is_mode || is_run || is_fstart || is_fdata || is_clear);
  assign in_col    = (state == COLLECT);
  // A word in the last countdown cycle wins over the timeout.
  assign timeout   = in_col && !DataInValid && (cnt == TO_LAST);
  assign complete  = in_col && is_fdata && (idx == 2'd3);
  assign Busy      = in_col;

  always_ff @(posedge ExtClk or posedge ExtReset) begin
    if (ExtReset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_fstart) state_nxt = COLLECT;
      COLLECT: if (complete || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt    = idx;
    bytes_nxt  = bytes;
    cnt_nxt    = '0;
    freq_nxt   = FreqWord;
    fvalid_nxt = FreqValid;
    mode_nxt   = Mode;
    enable_nxt = Enable;
    err_set    = '0;
    if (in_col && !DataInValid && !timeout) cnt_nxt = cnt + 1'b1;
    if (is_mode) mode_nxt = pl[MODE_W-1:0];
    if (is_run)  enable_nxt = pl[0];
    if (is_bad)  err_set[0] = 1'b1;
    if (timeout) err_set[1] = 1'b1;
    if (is_fstart) begin
      bytes_nxt[0] = pl;
      idx_nxt      = 2'd1;
      if (in_col) err_set[2] = 1'b1;
    end
    if (is_fdata) begin
      if (!in_col) err_set[2] = 1'b1;
      else begin
        idx_nxt = idx + 2'd1;
        case (idx)
          2'd1:    bytes_nxt[1] = pl;
          2'd2:    bytes_nxt[2] = pl;
          default: ;
        endcase
      end
    end
    if (FreqValid && FreqReady) fvalid_nxt = 1'b0;
    if (complete) begin
      freq_nxt   = {pl, bytes[2], bytes[1], bytes[0]};
      fvalid_nxt = 1'b1;
      if (FreqValid && !FreqReady) err_set[3] = 1'b1;
    end
    err_nxt = (is_clear ? 4'b0 : ErrFlags) | err_set;
  end

  always_ff @(posedge ExtClk or posedge ExtReset) begin
    if (ExtReset) begin
      idx       <= '0;
      bytes     <= '0;
      cnt       <= '0;
      FreqWord  <= FREQ_INIT;
      FreqValid <= 1'b0;
      Mode      <= '0;
      Enable    <= 1'b0;
      ErrFlags  <= '0;
    end else begin
      idx       <= idx_nxt;
      bytes     <= bytes_nxt;
      cnt       <= cnt_nxt;
      FreqWord  <= freq_nxt;
      FreqValid <= fvalid_nxt;
      Mode      <= mode_nxt;
      Enable    <= enable_nxt;
      ErrFlags  <= err_nxt;
    end
  end
endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: transfers, commands, timeout, overrun, async reset.
module tb_rx_cmd_decoder;
  logic        ExtClk = 1'b0;
  logic        ExtReset;
  logic [11:0] DataIn;
  logic        DataInValid;
  logic [31:0] FreqWord;
  logic        FreqValid;
  logic        FreqReady;
  logic [1:0]  Mode;
  logic        Enable;
  logic        Busy;
  logic [3:0]  ErrFlags;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] INIT = 32'h05C63C7D;

  rx_cmd_decoder #(.TIMEOUT_CYC(16), .FREQ_INIT(INIT), .MODE_W(2)) dut (
    .ExtClk(ExtClk), .ExtReset(ExtReset), .DataIn(DataIn), .DataInValid(DataInValid),
    .FreqWord(FreqWord), .FreqValid(FreqValid), .FreqReady(FreqReady), .Mode(Mode),
    .Enable(Enable), .Busy(Busy), .ErrFlags(ErrFlags)
  );

  always #5 ExtClk = ~ExtClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] w);
    DataIn = w;
    DataInValid = 1'b1;
    @(posedge ExtClk); #1;
    DataInValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge ExtClk); #1; end
  endtask

  initial begin
    ExtReset = 1'b1; DataIn = '0; DataInValid = 1'b0; FreqReady = 1'b0;
    #23;
    chk("rst_freq", FreqWord, INIT);
    chk("rst_valid", FreqValid, 0);
    chk("rst_mode", Mode, 0);
    chk("rst_enable", Enable, 0);
    chk("rst_err", ErrFlags, 0);
    chk("rst_busy", Busy, 0);
    @(posedge ExtClk); #1; ExtReset = 1'b0;

    // basic transfer, then handshake
    send(12'h378);
    chk("xfer_busy", Busy, 1);
    send(12'h456); send(12'h434); send(12'h412);
    chk("xfer_word", FreqWord, 32'h12345678);
    chk("xfer_valid", FreqValid, 1);
    chk("xfer_idle", Busy, 0);
    idle(5);
    chk("xfer_hold", FreqValid, 1);
    FreqReady = 1'b1; idle(1); FreqReady = 1'b0;
    chk("xfer_ack", FreqValid, 0);
    chk("xfer_err", ErrFlags, 0);

    // commands
    send(12'h102); chk("cmd_mode", Mode, 2);
    send(12'h201); chk("cmd_run", Enable, 1);
    send(12'h4AA); chk("cmd_seq", ErrFlags, 4'b0100);
    send(12'h700); chk("cmd_bad", ErrFlags, 4'b0101);
    send(12'hF00); chk("cmd_clear", ErrFlags, 0);

    // timeout after 16 silent cycles
    send(12'h311);
    idle(15);
    chk("to_still_busy", Busy, 1);
    idle(1);
    chk("to_busy", Busy, 0);
    chk("to_err", ErrFlags, 4'b0010);
    chk("to_word", FreqWord, 32'h12345678);
    chk("to_valid", FreqValid, 0);
    send(12'hF00);
    // word in the timeout cycle is processed instead
    send(12'h311);
    idle(15);
    send(12'h422);
    chk("nto_busy", Busy, 1);
    chk("nto_err", ErrFlags, 0);
    send(12'h433); send(12'h444);
    chk("nto_word", FreqWord, 32'h44332211);
    chk("nto_valid", FreqValid, 1);
    chk("nto_err2", ErrFlags, 0);

    // overrun: second completion while previous still pending
    send(12'h355); send(12'h466); send(12'h477); send(12'h488);
    chk("ovr_word", FreqWord, 32'h88776655);
    chk("ovr_valid", FreqValid, 1);
    chk("ovr_err", ErrFlags, 4'b1000);
    send(12'hF00);
    send(12'h301); send(12'h402); send(12'h403);
    FreqReady = 1'b1; send(12'h404); FreqReady = 1'b0;
    chk("novr_word", FreqWord, 32'h04030201);
    chk("novr_valid", FreqValid, 1);
    chk("novr_err", ErrFlags, 0);

    // bad opcode mid-transfer leaves FSM in COLLECT
    send(12'h3AA); send(12'h500);
    chk("bad_busy", Busy, 1);
    chk("bad_err", ErrFlags, 4'b0001);
    send(12'hF00);

    // async reset mid-transfer
    send(12'h311); send(12'h422);
    #2 ExtReset = 1'b1;
    #2 chk("arst_busy", Busy, 0);
    chk("arst_valid", FreqValid, 0);
    ExtReset = 1'b0;
    @(posedge ExtClk); #1;
    send(12'h433);
    chk("arst_err", ErrFlags, 4'b0100);
    chk("arst_busy2", Busy, 0);
    chk("arst_valid2", FreqValid, 0);
    chk("arst_word", FreqWord, INIT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
